// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Response checker that sits beside a 2-input gate block. Each strobed
//   {a,b,y} sample is registered into a one-entry stage, then compared one
//   edge later against TRUTH_TABLE[{a,b}]. Mismatches are counted with
//   saturation, and the input vectors seen are tracked as a coverage mask.
//   A small FSM (IDLE/CHECK/DONE) decides when the run is complete. A run
//   ends either when all four vectors have been seen or when the cycle
//   budget runs out.

module gate_truth_checker #(
  parameter logic [3:0] TRUTH_TABLE = 4'b1001,  // expected y indexed by {a,b}
  parameter int         ERR_W       = 8,        // err_count width (saturating)
  parameter int         TIMEOUT     = 64        // CHECK cycles before forced DONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic [1:0]       first_err_vec,
  output logic             done,
  output logic             pass,
  output logic             timed_out
);

  // Timer must be able to hold TIMEOUT itself; it steps once more on the
  // edge that leaves CHECK.
  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One captured sample waiting for its compare.
  typedef struct packed {
    logic       valid;
    logic [1:0] vec;   // {a,b}
    logic       y;
  } stage_t;

  state_t           state;
  state_t           state_next;
  stage_t           stage;
  logic [TMR_W-1:0] timer;

  logic       capture;      // sample accepted into the stage this edge
  logic       cmp_en;       // staged sample is compared this edge
  logic       cmp_err;      // staged sample disagrees with the table
  logic [3:0] cov_next;     // coverage as it will be after this edge
  logic       cov_full;     // this edge completes coverage
  logic       timeout_hit;  // this edge exhausts the budget without full coverage

  // Compare path and completion conditions, shared by FSM and datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    cov_next    = coverage;
    capture     = (state == S_CHECK) && sample_valid && !start;
    // A start discards whatever sits in the stage, so it is never compared.
    cmp_en      = stage.valid && !start;
    cmp_err     = cmp_en && (stage.y != TRUTH_TABLE[stage.vec]);
    if (cmp_en) begin
      cov_next[stage.vec] = 1'b1;
    end
    cov_full    = (cov_next == 4'b1111);
    // Coverage completing on the same edge wins over the timeout.
    timeout_hit = (state == S_CHECK) && (timer == TMR_LAST) && !cov_full;
  end

  // Next-state logic: start always (re)enters CHECK; CHECK ends on coverage or timeout.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (start)                        state_next = S_CHECK;
        else if (cov_full || timeout_hit) state_next = S_DONE;
      end
      S_DONE: begin
        if (start) state_next = S_CHECK;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Stage register: capture {a,b,y} in CHECK; reset and start empty it.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      stage <= '0;
    end else begin
      stage.valid <= capture;
      stage.vec   <= {a, b};
      stage.y     <= y;
    end
  end

  // CHECK-cycle timer; cleared on start, frozen outside CHECK.
  always_ff @(posedge clk) begin
    if (rst || start)          timer <= '0;
    else if (state == S_CHECK) timer <= timer + TMR_W'(1);
  end

  // Mismatch pulse, one cycle after the compare edge's inputs were staged.
  always_ff @(posedge clk) begin
    if (rst) mismatch <= 1'b0;
    else     mismatch <= cmp_err;
  end

  // Saturating error counter; holds at all-ones once reached.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      err_count <= '0;
    end else if (cmp_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  // Vector of the first mismatch since start.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      first_err_vec <= 2'b00;
    end else if (cmp_err && (err_count == '0)) begin
      first_err_vec <= stage.vec;
    end
  end

  // Coverage mask; drained compares after leaving CHECK still update it.
  always_ff @(posedge clk) begin
    if (rst || start) coverage <= 4'b0000;
    else              coverage <= cov_next;
  end

  // Timeout flag: records that DONE was forced by the cycle budget.
  always_ff @(posedge clk) begin
    if (rst || start)     timed_out <= 1'b0;
    else if (timeout_hit) timed_out <= 1'b1;
  end

  // pass follows err_count, so a late drained error still revokes it.
  assign done = (state == S_DONE);
  assign pass = done && !timed_out && (err_count == '0);

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
//   Two checker instances share one stimulus stream: u1 is the default XNOR
//   build, u2 an AND table with a 2-bit counter and an 8-cycle budget. A
//   behavioural model per instance tracks what the checker must report.
//   Every output of both instances is compared after every clock edge.

module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       y = 1'b0;

  logic       u1_mismatch, u1_done, u1_pass, u1_timed_out;
  logic [7:0] u1_err_count;
  logic [3:0] u1_coverage;
  logic [1:0] u1_first_err_vec;

  logic       u2_mismatch, u2_done, u2_pass, u2_timed_out;
  logic [1:0] u2_err_count;
  logic [3:0] u2_coverage;
  logic [1:0] u2_first_err_vec;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  gate_truth_checker u1 (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sample_valid  (sample_valid),
    .a             (a),
    .b             (b),
    .y             (y),
    .mismatch      (u1_mismatch),
    .err_count     (u1_err_count),
    .coverage      (u1_coverage),
    .first_err_vec (u1_first_err_vec),
    .done          (u1_done),
    .pass          (u1_pass),
    .timed_out     (u1_timed_out)
  );

  gate_truth_checker #(
    .TRUTH_TABLE (4'b1000),
    .ERR_W       (2),
    .TIMEOUT     (8)
  ) u2 (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sample_valid  (sample_valid),
    .a             (a),
    .b             (b),
    .y             (y),
    .mismatch      (u2_mismatch),
    .err_count     (u2_err_count),
    .coverage      (u2_coverage),
    .first_err_vec (u2_first_err_vec),
    .done          (u2_done),
    .pass          (u2_pass),
    .timed_out     (u2_timed_out)
  );

  // ---------------- reference model (index 0 = u1, 1 = u2) ----------------
  // mode: 0 idle, 1 checking, 2 finished
  bit [3:0] m_tt[2]   = '{4'b1001, 4'b1000};
  int       m_emax[2] = '{255, 3};
  int       m_tmo[2]  = '{64, 8};

  int       m_mode[2];
  int       m_errs[2];
  bit [3:0] m_cov[2];
  bit [1:0] m_first[2];
  bit       m_tout[2];
  int       m_cycles[2];   // CHECK edges since start
  bit       m_mism[2];
  bit       m_pv[2];       // a sample is waiting to be judged
  bit [1:0] m_pvec[2];
  bit       m_py[2];

  task automatic model_clear(input int k);
    m_errs[k] = 0;  m_cov[k] = '0;    m_first[k] = '0; m_tout[k] = 0;
    m_cycles[k] = 0; m_mism[k] = 0;   m_pv[k] = 0;
  endtask

  // Advance one model by one clock edge using the inputs present at that edge.
  task automatic model_step(input int k);
    bit       judge;
    bit       wrong;
    bit [1:0] idx;
    bit [3:0] tt;
    if (rst) begin
      model_clear(k);
      m_mode[k] = 0;
      return;
    end
    tt    = m_tt[k];
    idx   = m_pvec[k];
    judge = m_pv[k] && !start;
    wrong = judge && (m_py[k] != tt[idx]);
    if (start) begin
      model_clear(k);
      m_mode[k] = 1;
    end else begin
      m_mism[k] = wrong;
      if (judge) m_cov[k][idx] = 1'b1;
      if (wrong) begin
        if (m_errs[k] == 0) m_first[k] = idx;
        if (m_errs[k] < m_emax[k]) m_errs[k]++;
      end
      if (m_mode[k] == 1) begin
        m_pv[k]   = sample_valid;
        m_pvec[k] = {a, b};
        m_py[k]   = y;
        m_cycles[k]++;
        if (m_cov[k] == 4'b1111) begin
          m_mode[k] = 2;
        end else if (m_cycles[k] == m_tmo[k]) begin
          m_mode[k] = 2;
          m_tout[k] = 1;
        end
      end else begin
        m_pv[k] = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    bit d0, d1;
    d0 = (m_mode[0] == 2);
    d1 = (m_mode[1] == 2);
    check("u1.mismatch",  32'(u1_mismatch),      32'(m_mism[0]));
    check("u1.err_count", 32'(u1_err_count),     32'(m_errs[0]));
    check("u1.coverage",  32'(u1_coverage),      32'(m_cov[0]));
    check("u1.first_err", 32'(u1_first_err_vec), 32'(m_first[0]));
    check("u1.done",      32'(u1_done),          32'(d0));
    check("u1.pass",      32'(u1_pass),          32'(d0 && !m_tout[0] && m_errs[0] == 0));
    check("u1.timed_out", 32'(u1_timed_out),     32'(m_tout[0]));
    check("u2.mismatch",  32'(u2_mismatch),      32'(m_mism[1]));
    check("u2.err_count", 32'(u2_err_count),     32'(m_errs[1]));
    check("u2.coverage",  32'(u2_coverage),      32'(m_cov[1]));
    check("u2.first_err", 32'(u2_first_err_vec), 32'(m_first[1]));
    check("u2.done",      32'(u2_done),          32'(d1));
    check("u2.pass",      32'(u2_pass),          32'(d1 && !m_tout[1] && m_errs[1] == 0));
    check("u2.timed_out", 32'(u2_timed_out),     32'(m_tout[1]));
  endtask

  // One clock: apply inputs, step models at the edge, compare 1 time unit later.
  task automatic drive(input bit st, input bit sv, input bit aa, input bit bb, input bit yy);
    start        = st;
    sample_valid = sv;
    a            = aa;
    b            = bb;
    y            = yy;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // XNOR reference for building correct/faulty DUT responses.
  function automatic bit xnor_y(input bit aa, input bit bb);
    return !(aa ^ bb);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_mode[k] = 0;
      m_pvec[k] = '0;
      m_py[k]   = 0;
    end

    // Reset state.
    do_reset(2);
    idle(2);

    // Correct XNOR responses on all four vectors.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 1);
    idle(2);
    check("t1.u1.coverage", 32'(u1_coverage), 32'hF);
    check("t1.u1.pass",     32'(u1_pass),     32'd1);

    // Faulty gate (y = a^b) against XNOR.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 0, 1, 1);
    drive(0, 1, 1, 1, 0);
    idle(2);
    check("t2.u1.err_count", 32'(u1_err_count),     32'd4);
    check("t2.u1.first_err", 32'(u1_first_err_vec), 32'd0);
    check("t2.u1.pass",      32'(u1_pass),          32'd0);

    // Only 00 and 11: the 8-cycle instance must time out.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, i[0], i[0], 1);
    check("t3.u2.timed_out", 32'(u2_timed_out), 32'd1);
    check("t3.u2.coverage",  32'(u2_coverage),  32'b1001);

    // Six wrong XNOR samples on three vectors: 2-bit counter sticks at 3.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bit [1:0] v;
      v = 2'(i % 3);
      drive(0, 1, v[1], v[0], !xnor_y(v[1], v[0]));
    end
    idle(2);
    check("t4.u2.err_count", 32'(u2_err_count), 32'd3);
    check("t4.u1.err_count", 32'(u1_err_count), 32'd6);

    // Restart mid-CHECK with errors logged and a sample in flight.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 0, 1, 1);
    drive(1, 1, 1, 0, 1);
    check("t5.u1.err_count", 32'(u1_err_count), 32'd0);
    check("t5.u1.coverage",  32'(u1_coverage),  32'd0);
    idle(3);

    // Reset mid-CHECK, then samples without start are ignored.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 1);
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(0, 1, i[1], i[0], 0);
    check("t6.u1.coverage",  32'(u1_coverage),  32'd0);
    check("t6.u1.err_count", 32'(u1_err_count), 32'd0);

    // Long run on a single vector so the 64-cycle instance also times out.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) drive(0, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));

    // Randomised traffic with occasional restarts and resets.
    for (int i = 0; i < 3000; i++) begin
      bit aa, bb;
      aa  = 1'($urandom_range(0, 1));
      bb  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0,
            aa, bb,
            xnor_y(aa, bb) ^ ($urandom_range(0, 5) == 0));
    end
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
